// File: rtl/quad_encoder_array.sv
// quad_encoder_array
//   Multi-channel quadrature encoder peripheral. Each channel synchronises and
//   glitch-filters its A/B/index inputs, keeps a signed position count with
//   illegal-transition detection, measures velocity over a shared sample
//   window, and captures the position on each index rising edge.
//
//   Optional build macro INDEX_RESET_EN: when defined, an index rising edge
//   also zeros the position (after latching it into idx_pos).
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   a, b, idx           asynchronous encoder inputs, one bit per channel
//   sel, rw, addr       bus select (rising edge starts an access), 1=read,
//                       address {channel[7:2], reg[1:0]}
//   wr_data             write data, sampled on the select edge
//   rd_data, rd_size    read data and reply size in bytes (0 = invalid addr)
//   rd_valid            one-cycle pulse when rd_data/rd_size update
//
// Register map per channel
//   0 (1 byte)  {err, idx_seen, 3'b0, A, B, I}; write bit7=1 clears flags
//   1 (4 bytes) position (sign-extended); write loads it
//   2 (4 bytes) velocity, read-only
//   3 (4 bytes) index capture position, read-only
module quad_encoder_array #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 3,
  parameter int SAMPLE_DIV = 120000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a,
  input  logic [NUM_CH-1:0] b,
  input  logic [NUM_CH-1:0] idx,
  input  logic              sel,
  input  logic              rw,
  input  logic [7:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic [2:0]        rd_size,
  output logic              rd_valid
);

  localparam int              NIN       = 3 * NUM_CH;
  localparam logic [3:0]      FILT_LAST = 4'(FILT_LEN - 1);
  localparam int              WIN_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_DIV - 1);

  function automatic logic [31:0] sext32(input logic signed [CNT_W-1:0] v);
    return 32'(v);
  endfunction

  // ---- stage p0/p1: two-flop synchroniser on {idx, b, a} ----
  logic [NIN-1:0] raw;
  logic [NIN-1:0] meta_p0;
  logic [NIN-1:0] sync_p1;
  logic [NIN-1:0] filt_p2;
  logic [3:0]     fcnt_p2 [NIN];

  assign raw = {idx, b, a};

  // ---- stage p2: stability filter ----
  // The filtered value follows the synchronised value only after FILT_LEN
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
      filt_p2 <= '0;
      for (int i = 0; i < NIN; i++) fcnt_p2[i] <= 4'd0;
    end else begin
      meta_p0 <= raw;
      sync_p1 <= meta_p0;
      for (int i = 0; i < NIN; i++) begin
        if (sync_p1[i] != filt_p2[i]) begin
          if (fcnt_p2[i] == FILT_LAST) begin
            filt_p2[i] <= sync_p1[i];
            fcnt_p2[i] <= 4'd0;
          end else begin
            fcnt_p2[i] <= fcnt_p2[i] + 4'd1;
          end
        end else begin
          fcnt_p2[i] <= 4'd0;
        end
      end
    end
  end

  logic [NUM_CH-1:0] a_f, b_f, i_f;
  assign a_f = filt_p2[NUM_CH-1:0];
  assign b_f = filt_p2[2*NUM_CH-1:NUM_CH];
  assign i_f = filt_p2[3*NUM_CH-1:2*NUM_CH];

  // ---- shared velocity window counter ----
  logic [WIN_W-1:0] win_cnt;
  logic             win_term;
  assign win_term = (win_cnt == WIN_LAST);

  always_ff @(posedge clk) begin
    if (reset)         win_cnt <= '0;
    else if (win_term) win_cnt <= '0;
    else               win_cnt <= win_cnt + 1'b1;
  end

  // ---- bus access detect ----
  logic       sel_d;
  logic       acc;
  logic       wr_en;
  logic [5:0] acc_ch;
  logic [1:0] acc_reg;

  assign acc     = sel & ~sel_d;
  assign wr_en   = acc & ~rw;
  assign acc_ch  = addr[7:2];
  assign acc_reg = addr[1:0];

  // ---- per-channel decode, position, velocity, index ----
  logic [31:0] rv0 [NUM_CH];
  logic [31:0] rv1 [NUM_CH];
  logic [31:0] rv2 [NUM_CH];
  logic [31:0] rv3 [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]              ab_cur;
    logic [1:0]              ab_prev_p3;
    logic                    i_prev_p3;
    logic signed [CNT_W-1:0] pos_p3;
    logic signed [CNT_W-1:0] snap_p3;
    logic signed [CNT_W-1:0] vel_p3;
    logic signed [CNT_W-1:0] idx_pos_p3;
    logic                    err_p3;
    logic                    seen_p3;
    logic                    step_up, step_dn, step_bad;
    logic                    idx_rise;
    logic                    wr_pos, wr_clr;

    assign ab_cur   = {a_f[c], b_f[c]};
    assign idx_rise = i_f[c] & ~i_prev_p3;
    assign wr_pos   = wr_en && (acc_ch == 6'(c)) && (acc_reg == 2'd1);
    assign wr_clr   = wr_en && (acc_ch == 6'(c)) && (acc_reg == 2'd0) && wr_data[7];

    // Forward is 00->10->11->01->00 on {A,B}; a double change is illegal.
    always_comb begin
      step_up  = 1'b0;
      step_dn  = 1'b0;
      step_bad = 1'b0;
      case ({ab_prev_p3, ab_cur})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: step_up  = 1'b1;
        4'b0001, 4'b0111, 4'b1110, 4'b1000: step_dn  = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: step_bad = 1'b1;
        default: ;
      endcase
    end

    // ---- stage p3: channel state ----
    always_ff @(posedge clk) begin
      if (reset) begin
        ab_prev_p3 <= 2'b00;
        i_prev_p3  <= 1'b0;
        pos_p3     <= '0;
        snap_p3    <= '0;
        vel_p3     <= '0;
        idx_pos_p3 <= '0;
        err_p3     <= 1'b0;
        seen_p3    <= 1'b0;
      end else begin
        ab_prev_p3 <= ab_cur;
        i_prev_p3  <= i_f[c];

        // Bus write has highest priority over counting (and index reset).
        if (wr_pos)       pos_p3 <= wr_data[CNT_W-1:0];
`ifdef INDEX_RESET_EN
        else if (idx_rise) pos_p3 <= '0;
`endif
        else if (step_up) pos_p3 <= pos_p3 + CNT_W'(1);
        else if (step_dn) pos_p3 <= pos_p3 - CNT_W'(1);

        if (idx_rise) idx_pos_p3 <= pos_p3;

        // Window terminal uses the registered position, so a same-cycle
        // write or count lands in the next window.
        if (win_term) begin
          vel_p3  <= pos_p3 - snap_p3;
          snap_p3 <= pos_p3;
        end

        // Set beats clear when both happen together.
        if (step_bad)    err_p3 <= 1'b1;
        else if (wr_clr) err_p3 <= 1'b0;

        if (idx_rise)    seen_p3 <= 1'b1;
        else if (wr_clr) seen_p3 <= 1'b0;
      end
    end

    assign rv0[c] = {24'd0, err_p3, seen_p3, 3'b000, a_f[c], b_f[c], i_f[c]};
    assign rv1[c] = sext32(pos_p3);
    assign rv2[c] = sext32(vel_p3);
    assign rv3[c] = sext32(idx_pos_p3);
  end

  // ---- read stage p0: latch the access on the select edge ----
  logic       rd_pend_p0;
  logic [5:0] rd_ch_p0;
  logic [1:0] rd_reg_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_d      <= 1'b0;
      rd_pend_p0 <= 1'b0;
      rd_ch_p0   <= 6'd0;
      rd_reg_p0  <= 2'd0;
    end else begin
      sel_d      <= sel;
      rd_pend_p0 <= acc & rw;
      if (acc & rw) begin
        rd_ch_p0  <= acc_ch;
        rd_reg_p0 <= acc_reg;
      end
    end
  end

  logic [31:0] rd_mux;
  logic [2:0]  sz_mux;

  always_comb begin
    rd_mux = 32'd0;
    sz_mux = 3'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_p0 == 6'(c)) begin
        case (rd_reg_p0)
          2'd0:    begin rd_mux = rv0[c]; sz_mux = 3'd1; end
          2'd1:    begin rd_mux = rv1[c]; sz_mux = 3'd4; end
          2'd2:    begin rd_mux = rv2[c]; sz_mux = 3'd4; end
          default: begin rd_mux = rv3[c]; sz_mux = 3'd4; end
        endcase
      end
    end
  end

  // ---- read stage p1: registered reply, held until the next read ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= 32'd0;
      rd_size  <= 3'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_pend_p0;
      if (rd_pend_p0) begin
        rd_data <= rd_mux;
        rd_size <= sz_mux;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Scoreboard bench for quad_encoder_array (NUM_CH=4, CNT_W=16, FILT_LEN=3,
// SAMPLE_DIV=100). Reads push the expected reply and its arrival cycle; a
// monitor pops and compares on every rd_valid pulse.
module tb_quad_encoder_array;

  localparam int NCH = 4;
  localparam int SDV = 100;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] a, b, idx;
  logic           sel, rw;
  logic [7:0]     addr;
  logic [31:0]    wr_data;
  logic [31:0]    rd_data;
  logic [2:0]     rd_size;
  logic           rd_valid;

  quad_encoder_array #(
    .NUM_CH(NCH), .CNT_W(16), .FILT_LEN(3), .SAMPLE_DIV(SDV)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .idx(idx),
    .sel(sel), .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_size(rd_size), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [31:0] q_data [$];
  logic [2:0]  q_size [$];
  int          q_cyc  [$];
  string       q_name [$];

  // Monitor: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (q_data.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got data=%h size=%0d, required no reply", rd_data, rd_size);
      end else begin
        logic [31:0] ed;
        logic [2:0]  es;
        int          ec;
        string       nm;
        ed = q_data.pop_front();
        es = q_size.pop_front();
        ec = q_cyc.pop_front();
        nm = q_name.pop_front();
        if (rd_data !== ed || rd_size !== es || cyc != ec) begin
          errors++;
          $display("FAIL %s: got data=%h size=%0d cycle=%0d, required data=%h size=%0d cycle=%0d",
                   nm, rd_data, rd_size, cyc, ed, es, ec);
        end
      end
    end
  end

  logic [1:0] qs [NCH];

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic step(input int ch, input bit up, input int hold);
    @(negedge clk);
    qs[ch] = up ? fwd(qs[ch]) : rev(qs[ch]);
    a[ch]  = qs[ch][1];
    b[ch]  = qs[ch][0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] ad, input logic [31:0] ed, input logic [2:0] es, input string nm);
    @(negedge clk);
    sel = 1'b1; rw = 1'b1; addr = ad;
    q_data.push_back(ed);
    q_size.push_back(es);
    q_cyc.push_back(cyc + 2);
    q_name.push_back(nm);
    @(negedge clk);
    sel = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] ad, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rw = 1'b0; addr = ad; wr_data = d;
    @(negedge clk);
    sel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    @(negedge clk);
    while ((cyc % SDV) != p) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  initial begin
    reset = 1'b1; a = '0; b = '0; idx = '0;
    sel = 1'b0; rw = 1'b0; addr = 8'd0; wr_data = 32'd0;
    for (int i = 0; i < NCH; i++) qs[i] = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_rd_size", 32'(rd_size), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;

    rd(8'h00, 32'h00, 3'd1, "ch0_status_after_reset");
    rd(8'h01, 32'h0, 3'd4, "ch0_pos_after_reset");

    for (int i = 0; i < 8; i++) step(0, 1'b1, 10);
    rd(8'h01, 32'h0000_0008, 3'd4, "ch0_fwd8");

    for (int i = 0; i < 3; i++) step(1, 1'b0, 10);
    rd(8'h05, 32'hFFFF_FFFD, 3'd4, "ch1_rev3");
    rd(8'h04, 32'h04, 3'd1, "ch1_status_ab10");

    // Two-cycle glitch on ch0 A is filtered out.
    @(negedge clk); a[0] = 1'b1;
    repeat (2) @(negedge clk); a[0] = 1'b0;
    repeat (10) @(negedge clk);
    rd(8'h01, 32'h0000_0008, 3'd4, "ch0_glitch_pos");
    rd(8'h00, 32'h00, 3'd1, "ch0_glitch_status");

    // Both bits toggle together: illegal, count held, err set.
    @(negedge clk); qs[0] = 2'b11; a[0] = 1'b1; b[0] = 1'b1;
    repeat (10) @(negedge clk);
    rd(8'h01, 32'h0000_0008, 3'd4, "ch0_illegal_pos");
    rd(8'h00, 32'h86, 3'd1, "ch0_err_set");
    wr(8'h00, 32'h80);
    rd(8'h00, 32'h06, 3'd1, "ch0_err_cleared");

    // 16-bit wrap on ch1.
    wr(8'h05, 32'h0000_FFFF);
    rd(8'h05, 32'hFFFF_FFFF, 3'd4, "ch1_pos_ffff");
    step(1, 1'b1, 10);
    rd(8'h05, 32'h0000_0000, 3'd4, "ch1_wrap_zero");

    // Velocity on ch2: +5 in one window, then -2 in the next.
    wait_phase(2);
    for (int i = 0; i < 5; i++) step(2, 1'b1, 10);
    wait_phase(5);
    rd(8'h0A, 32'h0000_0005, 3'd4, "ch2_vel_plus5");
    step(2, 1'b0, 10);
    step(2, 1'b0, 10);
    wait_phase(5);
    rd(8'h0A, 32'hFFFF_FFFE, 3'd4, "ch2_vel_minus2");
    wr(8'h0A, 32'h55);
    rd(8'h0A, 32'hFFFF_FFFE, 3'd4, "ch2_vel_readonly");

    // Index capture on ch3.
    wr(8'h0D, 32'd42);
    @(negedge clk); idx[3] = 1'b1;
    repeat (10) @(negedge clk); idx[3] = 1'b0;
    repeat (10) @(negedge clk);
    rd(8'h0F, 32'd42, 3'd4, "ch3_idx_pos");
    rd(8'h0C, 32'h40, 3'd1, "ch3_idx_seen");
`ifdef INDEX_RESET_EN
    rd(8'h0D, 32'd0, 3'd4, "ch3_pos_index_reset");
`else
    rd(8'h0D, 32'd42, 3'd4, "ch3_pos_kept");
`endif

    // Invalid channel.
    wr(8'h11, 32'hDEAD);
    rd(8'h11, 32'd0, 3'd0, "invalid_channel");

    // Write lands on the same edge as a forward count on ch0 (11 -> 01):
    // raw change at negedge N updates position at posedge N+6, and the
    // write's select edge is detected at posedge N+6.
    step(0, 1'b1, 4);
    wr(8'h01, 32'h1234);
    repeat (10) @(negedge clk);
    rd(8'h01, 32'h0000_1234, 3'd4, "write_beats_count");

    // Reset during an access: no reply, state cleared.
    @(negedge clk); a = '0; b = '0; idx = '0;
    repeat (12) @(negedge clk);
    sel = 1'b1; rw = 1'b1; addr = 8'h01; reset = 1'b1;
    @(negedge clk); reset = 1'b0; sel = 1'b0;
    repeat (6) @(negedge clk);
    rd(8'h01, 32'd0, 3'd4, "pos_after_midop_reset");
    rd(8'h00, 32'h00, 3'd1, "status_after_midop_reset");

    repeat (10) @(negedge clk);
    if (q_data.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_replies: got %0d outstanding, required 0", q_data.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
